// File: rtl/cpu.sv
// SPAM-1 8-bit CPU core.
// Executes one 48-bit instruction per clock, fetched from a 64K x 48 program
// ROM held as six byte lanes. Clock low is the execute phase (buses settle);
// the rising edge commits the target write, the flags load and the PC update.
// Ports:
//   clk            single clock, rising edge commits
//   _RESET_SWITCH  asynchronous active-high reset
// There are no functional outputs; state is observed hierarchically.

// 8-bit register with write enable (MAR halves, flags).
//   clk, rst  clock and async active-high reset
//   we, d     write enable and data
//   Q         current value
module cpu_reg8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] Q
);
  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we) q_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;
endmodule

// Four-entry register file, one write port, two combinational read ports.
//   we/wsel/wdata  write port; asel/adata, bsel/bdata  read ports
module cpu_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] wsel,
  input  logic [7:0] wdata,
  input  logic [1:0] asel,
  input  logic [1:0] bsel,
  output logic [7:0] adata,
  output logic [7:0] bdata
);
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];

  function automatic logic [7:0] get(input logic [1:0] idx);
    get = regs_q[idx];
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    if (we) regs_d[wsel] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign adata = get(asel);
  assign bdata = get(bsel);
endmodule

// Program counter with PCHITMP staging register.
//   advance   increment PC (wraps at 0xFFFF)
//   load_hi   load PCHITMP from data, PC still advances
//   jump      PC <= {PCHITMP, data}
module cpu_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        load_hi,
  input  logic        jump,
  input  logic [7:0]  data,
  output logic [15:0] pc_addr
);
  logic [15:0] pc_q, pc_d;
  logic [7:0]  PCHITMP, pchitmp_d;

  always_comb begin
    pc_d      = pc_q;
    pchitmp_d = PCHITMP;
    if (load_hi) pchitmp_d = data;
    if (jump)         pc_d = {PCHITMP, data};
    else if (advance) pc_d = pc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      PCHITMP <= '0;
    end else begin
      pc_q    <= pc_d;
      PCHITMP <= pchitmp_d;
    end
  end

  assign pc_addr = pc_q;
endmodule

// Program ROM, six byte lanes (rom_1 = bits [7:0]). The programming port is
// tied off in the core; lanes are normally preloaded from outside.
module cpu_ctrl (
  input  logic        clk,
  input  logic        prog_we,
  input  logic [15:0] prog_addr,
  input  logic [47:0] prog_data,
  input  logic [15:0] pc_addr,
  output logic [47:0] instruction
);
  logic [7:0] rom_1 [0:65535];
  logic [7:0] rom_2 [0:65535];
  logic [7:0] rom_3 [0:65535];
  logic [7:0] rom_4 [0:65535];
  logic [7:0] rom_5 [0:65535];
  logic [7:0] rom_6 [0:65535];
  logic [7:0] instruction_1, instruction_2, instruction_3;
  logic [7:0] instruction_4, instruction_5, instruction_6;

  always_ff @(posedge clk) begin
    if (prog_we) begin
      rom_1[prog_addr] <= prog_data[7:0];
      rom_2[prog_addr] <= prog_data[15:8];
      rom_3[prog_addr] <= prog_data[23:16];
      rom_4[prog_addr] <= prog_data[31:24];
      rom_5[prog_addr] <= prog_data[39:32];
      rom_6[prog_addr] <= prog_data[47:40];
    end
  end

  assign instruction_1 = rom_1[pc_addr];
  assign instruction_2 = rom_2[pc_addr];
  assign instruction_3 = rom_3[pc_addr];
  assign instruction_4 = rom_4[pc_addr];
  assign instruction_5 = rom_5[pc_addr];
  assign instruction_6 = rom_6[pc_addr];
  assign instruction = {instruction_6, instruction_5, instruction_4,
                        instruction_3, instruction_2, instruction_1};
endmodule

module cpu (
  input logic clk,
  input logic _RESET_SWITCH
);
  localparam logic [4:0] T_MARLO = 5'd4, T_MARHI = 5'd5, T_RAM = 5'd6;
  localparam logic [4:0] T_HALT = 5'd7, T_PCHITMP = 5'd8, T_PCLO = 5'd9;

  logic        rst;
  logic [47:0] instruction;
  logic [4:0]  alu_op, tdev;
  logic [2:0]  adev;
  logic [3:0]  bdev, condition;
  logic        set_flags_n, cond_mode, amode;
  logic [15:0] address, pc_addr, ram_addr;
  logic [7:0]  immed8, abus, bbus, alu_result_bus, ram_rd;
  logic [7:0]  rf_adata, rf_bdata, marlo, marhi, flags_q, flags_new;
  logic [8:0]  r9;
  logic [15:0] prod;
  logic        ovf, cond, do_exec_n, exec, halted_q, halted_d;
  logic [7:0]  ram [0:65535];

  assign rst = _RESET_SWITCH;
  assign {alu_op, tdev, adev, bdev, condition, set_flags_n, cond_mode, amode,
          address, immed8} = instruction;

  cpu_ctrl ctrl (.clk(clk), .prog_we(1'b0), .prog_addr(16'h0000), .prog_data(48'h0),
                 .pc_addr(pc_addr), .instruction(instruction));

  cpu_regfile regFile (.clk(clk), .rst(rst), .we(exec && tdev[4:2] == 3'd0),
                       .wsel(tdev[1:0]), .wdata(alu_result_bus), .asel(adev[1:0]),
                       .bsel(bdev[1:0]), .adata(rf_adata), .bdata(rf_bdata));

  cpu_reg8 MARLO (.clk(clk), .rst(rst), .we(exec && tdev == T_MARLO),
                  .d(alu_result_bus), .Q(marlo));
  cpu_reg8 MARHI (.clk(clk), .rst(rst), .we(exec && tdev == T_MARHI),
                  .d(alu_result_bus), .Q(marhi));
  cpu_reg8 status_register_czonGLEN (.clk(clk), .rst(rst), .we(exec && !set_flags_n),
                                     .d(flags_new), .Q(flags_q));

  // A halt freezes the PC on the halt instruction itself.
  cpu_pc PC (.clk(clk), .rst(rst),
             .advance(!halted_q && !(exec && tdev == T_HALT)),
             .load_hi(exec && tdev == T_PCHITMP), .jump(exec && tdev == T_PCLO),
             .data(alu_result_bus), .pc_addr(pc_addr));

  assign ram_addr = amode ? {marhi, marlo} : address;
  assign ram_rd   = ram[ram_addr];

  always_comb begin
    abus = '0;
    case (adev)
      3'd0, 3'd1, 3'd2, 3'd3: abus = rf_adata;
      3'd4:    abus = marlo;
      3'd5:    abus = marhi;
      3'd6:    abus = immed8;
      default: abus = '0;
    endcase
  end

  always_comb begin
    bbus = '0;
    case (bdev)
      4'd0, 4'd1, 4'd2, 4'd3: bbus = rf_bdata;
      4'd4:    bbus = marlo;
      4'd5:    bbus = marhi;
      4'd6:    bbus = immed8;
      4'd7:    bbus = ram_rd;
      default: bbus = '0;
    endcase
  end

  // ALU: bit 8 of r9 is the carry (borrow for subtraction).
  assign prod = {8'h00, abus} * {8'h00, bbus};

  always_comb begin
    r9  = '0;
    ovf = 1'b0;
    case (alu_op)
      5'd1:  r9 = {1'b0, abus};
      5'd2:  r9 = {1'b0, bbus};
      5'd3:  begin r9 = 9'd0 - {1'b0, abus}; ovf = (abus == 8'h80); end
      5'd4:  begin r9 = 9'd0 - {1'b0, bbus}; ovf = (bbus == 8'h80); end
      5'd5:  begin r9 = {1'b0, abus} + {1'b0, bbus};
                   ovf = (abus[7] == bbus[7]) && (r9[7] != abus[7]); end
      5'd6:  begin r9 = {1'b0, abus} - {1'b0, bbus};
                   ovf = (abus[7] != bbus[7]) && (r9[7] != abus[7]); end
      5'd7:  begin r9 = {1'b0, bbus} - {1'b0, abus};
                   ovf = (abus[7] != bbus[7]) && (r9[7] != bbus[7]); end
      5'd8:  begin r9 = {1'b0, abus} + {1'b0, bbus} + {8'h00, flags_q[7]};
                   ovf = (abus[7] == bbus[7]) && (r9[7] != abus[7]); end
      5'd9:  begin r9 = {1'b0, abus} - {1'b0, bbus} - {8'h00, flags_q[7]};
                   ovf = (abus[7] != bbus[7]) && (r9[7] != abus[7]); end
      5'd10: r9 = {1'b0, prod[7:0]};
      5'd11: r9 = {1'b0, prod[15:8]};
      5'd12: r9 = {1'b0, abus & bbus};
      5'd13: r9 = {1'b0, abus | bbus};
      5'd14: r9 = {1'b0, abus ^ bbus};
      5'd15: r9 = {1'b0, ~abus};
      5'd16: r9 = {1'b0, ~bbus};
      5'd17: begin r9 = {1'b0, abus} + 9'd1; ovf = (abus == 8'h7F); end
      5'd18: begin r9 = {1'b0, abus} - 9'd1; ovf = (abus == 8'h80); end
      default: r9 = '0;
    endcase
  end

  assign alu_result_bus = r9[7:0];
  assign flags_new = {r9[8], alu_result_bus == 8'h00, ovf, alu_result_bus[7],
                      abus > bbus, abus < bbus, abus == bbus, abus != bbus};

  always_comb begin
    cond = 1'b0;
    case (condition)
      4'd0:    cond = 1'b1;
      4'd1:    cond = flags_q[7];
      4'd2:    cond = flags_q[6];
      4'd3:    cond = flags_q[5];
      4'd4:    cond = flags_q[4];
      4'd5:    cond = flags_q[3];
      4'd6:    cond = flags_q[2];
      4'd7:    cond = flags_q[1];
      4'd8:    cond = flags_q[0];
      default: cond = 1'b0;
    endcase
  end

  assign do_exec_n = !(cond ^ cond_mode);
  assign exec      = !do_exec_n && !halted_q;

  always_comb begin
    halted_d = halted_q;
    if (exec && tdev == T_HALT) halted_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  // RAM is not reset; a write is simply blocked while reset is held.
  always_ff @(posedge clk) begin
    if (exec && tdev == T_RAM && !rst) ram[ram_addr] <= alu_result_bus;
  end
endmodule

// File: tb/tb_cpu.sv
module tb_cpu;
  logic clk = 1'b0;
  logic rst_sw = 1'b0;
  int   checks = 0;
  int   failures = 0;

  cpu dut (.clk(clk), ._RESET_SWITCH(rst_sw));

  always #5 clk = ~clk;

  function automatic logic [47:0] mk(input logic [4:0] alu, input logic [4:0] tdev,
                                     input logic [2:0] adev, input logic [3:0] bdev,
                                     input logic [3:0] cond, input logic setf_n,
                                     input logic inv, input logic amode,
                                     input logic [15:0] addr, input logic [7:0] imm);
    return {alu, tdev, adev, bdev, cond, setf_n, inv, amode, addr, imm};
  endfunction

  // Load target with immediate via B bus, no flags.
  function automatic logic [47:0] ldi(input logic [4:0] tdev, input logic [7:0] imm);
    return mk(5'd2, tdev, 3'd7, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, imm);
  endfunction

  function automatic logic [47:0] nop();
    return mk(5'd0, 5'd31, 3'd7, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
  endfunction

  task automatic load(input logic [15:0] a, input logic [47:0] ins);
    dut.ctrl.rom_1[a] = ins[7:0];
    dut.ctrl.rom_2[a] = ins[15:8];
    dut.ctrl.rom_3[a] = ins[23:16];
    dut.ctrl.rom_4[a] = ins[31:24];
    dut.ctrl.rom_5[a] = ins[39:32];
    dut.ctrl.rom_6[a] = ins[47:40];
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_cpu();
    rst_sw = 1'b1;
    @(negedge clk);
    rst_sw = 1'b0;
  endtask

  task automatic test_reset();
    load(16'h0000, ldi(5'd0, 8'h33));
    #1 rst_sw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dut.pc_addr !== 16'h0000) begin failures++;
      $display("FAIL reset_pc got=%h exp=0000", dut.pc_addr); end
    checks++; if (dut.status_register_czonGLEN.Q !== 8'h00) begin failures++;
      $display("FAIL reset_flags got=%h exp=00", dut.status_register_czonGLEN.Q); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dut.regFile.regs_q[i] !== 8'h00) begin failures++;
        $display("FAIL reset_reg%0d got=%h exp=00", i, dut.regFile.regs_q[i]); end
    end
    rst_sw = 1'b0;
    step(1);
    checks++; if (dut.pc_addr !== 16'h0001) begin failures++;
      $display("FAIL reset_first_pc got=%h exp=0001", dut.pc_addr); end
    checks++; if (dut.regFile.regs_q[0] !== 8'h33) begin failures++;
      $display("FAIL reset_first_exec got=%h exp=33", dut.regFile.regs_q[0]); end
  endtask

  task automatic test_add_flags();
    load(16'h0000, ldi(5'd0, 8'h7F));
    load(16'h0001, ldi(5'd1, 8'h01));
    load(16'h0002, mk(5'd5, 5'd2, 3'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00));
    reset_cpu();
    step(3);
    checks++; if (dut.regFile.regs_q[2] !== 8'h80) begin failures++;
      $display("FAIL add_result got=%h exp=80", dut.regFile.regs_q[2]); end
    // C=0 Z=0 O=1 N=1 G=1 L=0 E=0 NE=1
    checks++; if (dut.status_register_czonGLEN.Q !== 8'h39) begin failures++;
      $display("FAIL add_flags got=%h exp=39", dut.status_register_czonGLEN.Q); end
  endtask

  task automatic test_carry();
    load(16'h0000, ldi(5'd0, 8'hFF));
    load(16'h0001, ldi(5'd1, 8'h01));
    load(16'h0002, mk(5'd5, 5'd0, 3'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00));
    load(16'h0003, mk(5'd8, 5'd2, 3'd0, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00));
    reset_cpu();
    step(3);
    checks++; if (dut.regFile.regs_q[0] !== 8'h00) begin failures++;
      $display("FAIL carry_result got=%h exp=00", dut.regFile.regs_q[0]); end
    // C=1 Z=1 O=0 N=0 G=1 L=0 E=0 NE=1
    checks++; if (dut.status_register_czonGLEN.Q !== 8'hC9) begin failures++;
      $display("FAIL carry_flags got=%h exp=c9", dut.status_register_czonGLEN.Q); end
    step(1);
    checks++; if (dut.regFile.regs_q[2] !== 8'h01) begin failures++;
      $display("FAIL adc_result got=%h exp=01", dut.regFile.regs_q[2]); end
    checks++; if (dut.status_register_czonGLEN.Q !== 8'hC9) begin failures++;
      $display("FAIL adc_flags_kept got=%h exp=c9", dut.status_register_czonGLEN.Q); end
  endtask

  task automatic test_alu();
    load(16'h0000, ldi(5'd0, 8'h10));
    load(16'h0001, ldi(5'd1, 8'h20));
    load(16'h0002, mk(5'd6, 5'd2, 3'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00));
    load(16'h0003, mk(5'd11, 5'd3, 3'd0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00));
    load(16'h0004, mk(5'd3, 5'd0, 3'd0, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00));
    reset_cpu();
    step(5);
    checks++; if (dut.regFile.regs_q[2] !== 8'hF0) begin failures++;
      $display("FAIL sub_result got=%h exp=f0", dut.regFile.regs_q[2]); end
    // C=1 Z=0 O=0 N=1 G=0 L=1 E=0 NE=1
    checks++; if (dut.status_register_czonGLEN.Q !== 8'h95) begin failures++;
      $display("FAIL sub_flags got=%h exp=95", dut.status_register_czonGLEN.Q); end
    checks++; if (dut.regFile.regs_q[3] !== 8'h02) begin failures++;
      $display("FAIL mulhi_result got=%h exp=02", dut.regFile.regs_q[3]); end
    checks++; if (dut.regFile.regs_q[0] !== 8'hF0) begin failures++;
      $display("FAIL neg_result got=%h exp=f0", dut.regFile.regs_q[0]); end
  endtask

  task automatic test_jump();
    load(16'h0000, ldi(5'd8, 8'h12));
    load(16'h0001, ldi(5'd9, 8'h34));
    load(16'h1234, mk(5'd2, 5'd8, 3'd7, 4'd6, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0, 8'h56));
    load(16'h1235, mk(5'd2, 5'd9, 3'd7, 4'd6, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00));
    load(16'h1236, mk(5'd2, 5'd9, 3'd7, 4'd6, 4'd2, 1'b1, 1'b1, 1'b0, 16'h0, 8'h78));
    reset_cpu();
    step(2);
    checks++; if (dut.pc_addr !== 16'h1234) begin failures++;
      $display("FAIL jump_pc got=%h exp=1234", dut.pc_addr); end
    checks++; if (dut.PC.PCHITMP !== 8'h12) begin failures++;
      $display("FAIL jump_pchitmp got=%h exp=12", dut.PC.PCHITMP); end
    step(1);
    checks++; if (dut.PC.PCHITMP !== 8'h12) begin failures++;
      $display("FAIL cond_pchitmp_kept got=%h exp=12", dut.PC.PCHITMP); end
    step(1);
    checks++; if (dut.pc_addr !== 16'h1236) begin failures++;
      $display("FAIL cond_jump_skipped got=%h exp=1236", dut.pc_addr); end
    step(1);
    checks++; if (dut.pc_addr !== 16'h1278) begin failures++;
      $display("FAIL invert_jump got=%h exp=1278", dut.pc_addr); end
  endtask

  task automatic test_ram();
    load(16'h0000, ldi(5'd5, 8'h01));
    load(16'h0001, ldi(5'd4, 8'h02));
    load(16'h0002, mk(5'd2, 5'd6, 3'd7, 4'd6, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'hAA));
    load(16'h0003, mk(5'd2, 5'd0, 3'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0102, 8'h00));
    load(16'h0004, mk(5'd5, 5'd6, 3'd6, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0102, 8'h01));
    load(16'h0005, mk(5'd2, 5'd1, 3'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0102, 8'h00));
    reset_cpu();
    step(4);
    checks++; if ({dut.MARHI.Q, dut.MARLO.Q} !== 16'h0102) begin failures++;
      $display("FAIL mar_value got=%h exp=0102", {dut.MARHI.Q, dut.MARLO.Q}); end
    checks++; if (dut.regFile.regs_q[0] !== 8'hAA) begin failures++;
      $display("FAIL ram_readback got=%h exp=aa", dut.regFile.regs_q[0]); end
    step(2);
    checks++; if (dut.regFile.regs_q[1] !== 8'hAB) begin failures++;
      $display("FAIL ram_rmw got=%h exp=ab", dut.regFile.regs_q[1]); end
  endtask

  task automatic test_halt();
    load(16'h0000, ldi(5'd0, 8'h11));
    load(16'h0001, mk(5'd0, 5'd7, 3'd7, 4'd8, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00));
    load(16'h0002, ldi(5'd0, 8'h22));
    reset_cpu();
    step(2);
    checks++; if (dut.pc_addr !== 16'h0001) begin failures++;
      $display("FAIL halt_pc got=%h exp=0001", dut.pc_addr); end
    step(10);
    checks++; if (dut.pc_addr !== 16'h0001) begin failures++;
      $display("FAIL halt_pc_frozen got=%h exp=0001", dut.pc_addr); end
    checks++; if (dut.regFile.regs_q[0] !== 8'h11) begin failures++;
      $display("FAIL halt_no_write got=%h exp=11", dut.regFile.regs_q[0]); end
    rst_sw = 1'b1;
    @(negedge clk);
    checks++; if (dut.pc_addr !== 16'h0000) begin failures++;
      $display("FAIL halt_reset_pc got=%h exp=0000", dut.pc_addr); end
    rst_sw = 1'b0;
    step(1);
    checks++; if (dut.regFile.regs_q[0] !== 8'h11) begin failures++;
      $display("FAIL halt_restart got=%h exp=11", dut.regFile.regs_q[0]); end
  endtask

  task automatic test_wrap();
    load(16'h0000, ldi(5'd8, 8'hFF));
    load(16'h0001, ldi(5'd9, 8'hFE));
    load(16'hFFFE, nop());
    load(16'hFFFF, ldi(5'd0, 8'h5A));
    reset_cpu();
    step(3);
    checks++; if (dut.pc_addr !== 16'hFFFF) begin failures++;
      $display("FAIL wrap_pre got=%h exp=ffff", dut.pc_addr); end
    step(1);
    checks++; if (dut.pc_addr !== 16'h0000) begin failures++;
      $display("FAIL wrap_pc got=%h exp=0000", dut.pc_addr); end
    checks++; if (dut.regFile.regs_q[0] !== 8'h5A) begin failures++;
      $display("FAIL wrap_exec got=%h exp=5a", dut.regFile.regs_q[0]); end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_carry();
    test_alu();
    test_jump();
    test_ram();
    test_halt();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
